// File: rtl/dom_mask_rng.sv
// dom_mask_rng: fresh-randomness source for the DOM shared GF(2^2) multipliers.
// A seeded 32-bit LFSR is advanced RAND_BITS steps per cycle. After a seed load it
// runs WARMUP_CYCLES advances and then serves one fresh word per requested cycle.
// A word is shown for exactly one cycle and is never shown twice.
module dom_mask_rng #(
   parameter int unsigned SHARES          = 2,
   parameter int unsigned WARMUP_CYCLES   = 16,
   parameter int unsigned RESEED_INTERVAL = 0
) (
   input  logic                           ClkxCI,
   input  logic                           RstxBI,
   input  logic [31:0]                    SeedxDI,
   input  logic                           SeedValidxSI,
   input  logic                           RandReqxSI,
   output logic                           ReadyxSO,
   output logic                           RandValidxSO,
   output logic [2*SHARES-1:0]            _BxDO,
   output logic [SHARES*(SHARES-1)-1:0]   _ZxDO,
   output logic                           ReseedReqxSO
);

   localparam int unsigned B_W       = 2 * SHARES;
   localparam int unsigned Z_W       = SHARES * (SHARES - 1);
   localparam int unsigned RAND_BITS = B_W + Z_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      RUN    = 2'd2
   } state_t;

   state_t      StatexDP;
   logic [31:0] LfsrxDP;
   logic [31:0] WarmCntxDP;
   logic [31:0] WordCntxDP;
   logic [31:0] AdvxD;
   logic [31:0] SeedFixxD;

   // One advance is RAND_BITS single LFSR steps chained combinationally.
   logic [31:0] StepChainxD [0:RAND_BITS];
   assign StepChainxD[0] = LfsrxDP;

   genvar gi;
   generate
      for (gi = 0; gi < RAND_BITS; gi++) begin : g_step
         assign StepChainxD[gi+1] = {StepChainxD[gi][30:0],
                                     StepChainxD[gi][31] ^ StepChainxD[gi][21] ^
                                     StepChainxD[gi][1]  ^ StepChainxD[gi][0]};
      end
   endgenerate

   assign AdvxD = StepChainxD[RAND_BITS];

   // The all-zero state would lock the LFSR, so a zero seed is replaced by 1.
   assign SeedFixxD = (SeedxDI == 32'd0) ? 32'd1 : SeedxDI;

   // Seed/warm-up/run sequencer with registered outputs; seed load beats requests.
   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         StatexDP     <= IDLE;
         LfsrxDP      <= 32'd1;
         WarmCntxDP   <= 32'd0;
         WordCntxDP   <= 32'd0;
         ReadyxSO     <= 1'b0;
         RandValidxSO <= 1'b0;
         _BxDO        <= '0;
         _ZxDO        <= '0;
         ReseedReqxSO <= 1'b0;
      end else begin
         // Outputs default to empty; only a granted RUN request fills them.
         RandValidxSO <= 1'b0;
         _BxDO        <= '0;
         _ZxDO        <= '0;

         if (SeedValidxSI) begin
            LfsrxDP      <= SeedFixxD;
            WarmCntxDP   <= WARMUP_CYCLES;
            WordCntxDP   <= 32'd0;
            ReseedReqxSO <= 1'b0;
            if (WARMUP_CYCLES == 0) begin
               StatexDP <= RUN;
               ReadyxSO <= 1'b1;
            end else begin
               StatexDP <= WARMUP;
               ReadyxSO <= 1'b0;
            end
         end else begin
            case (StatexDP)
               WARMUP: begin
                  LfsrxDP    <= AdvxD;
                  WarmCntxDP <= WarmCntxDP - 32'd1;
                  if (WarmCntxDP == 32'd1) begin
                     StatexDP <= RUN;
                     ReadyxSO <= 1'b1;
                  end
               end
               RUN: begin
                  if (RandReqxSI) begin
                     LfsrxDP      <= AdvxD;
                     _BxDO        <= AdvxD[B_W-1:0];
                     _ZxDO        <= AdvxD[RAND_BITS-1:B_W];
                     RandValidxSO <= 1'b1;
                     // Word counter saturates at the interval; the request stays sticky.
                     if ((RESEED_INTERVAL != 0) && (WordCntxDP != RESEED_INTERVAL)) begin
                        WordCntxDP <= WordCntxDP + 32'd1;
                        if (WordCntxDP + 32'd1 == RESEED_INTERVAL) begin
                           ReseedReqxSO <= 1'b1;
                        end
                     end
                  end
               end
               default: begin
                  StatexDP <= IDLE;
                  ReadyxSO <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/dom_mask_rng.md
Name: dom_mask_rng

Overview:
- Fresh-randomness source for the DOM shared GF(2^2) multipliers in the masked AES S-box.
- Sits directly upstream of the multiplier and drives its blinding shares B and remask shares Z.
- A seeded 32-bit LFSR runs a seed/warm-up/run state machine and delivers one fresh, never-reused word per granted request cycle.
- A delivered-word counter raises a reseed request.

Parameters:
- SHARES, 2, number of masking shares (legal 2..5).
- WARMUP_CYCLES, 16, LFSR advance cycles after a seed load before output starts (0 legal).
- RESEED_INTERVAL, 0, delivered words before ReseedReqxSO asserts; 0 = never.
- Derived, not overridable: RAND_BITS = 2*SHARES + SHARES*(SHARES-1), which is at most 32.

Ports:
- ClkxCI  in  1  clock.
- RstxBI  in  1  reset, asynchronous, active-low.
- SeedxDI  in  32  seed value.
- SeedValidxSI  in  1  load SeedxDI this cycle.
- RandReqxSI  in  1  consumer requests one fresh word this cycle.
- ReadyxSO  out  1  generator is in RUN.
- RandValidxSO  out  1  _BxDO/_ZxDO hold a fresh word this cycle.
- _BxDO  out  2*SHARES  blinding shares (multiplier B input).
- _ZxDO  out  SHARES*(SHARES-1)  remask shares (multiplier Z input).
- ReseedReqxSO  out  1  sticky reseed request.

Behaviour:
- Reset (async, RstxBI=0):
  - LFSR state = 32'h1, FSM = IDLE, warm-up and word counters = 0.
  - All outputs = 0.
- LFSR single step:
  - fb = s[31]^s[21]^s[1]^s[0]; s <= {s[30:0], fb}.
  - One "advance" = RAND_BITS single steps, unrolled combinationally in one cycle.
- Seed load:
  - State = SeedxDI, or 32'h1 if SeedxDI == 0.
  - Warm-up counter = WARMUP_CYCLES; word counter = 0; ReseedReqxSO cleared.
  - Next FSM state = WARMUP, or RUN if WARMUP_CYCLES == 0.
- FSM states:
  - IDLE: wait for SeedValidxSI; RandReqxSI ignored.
  - WARMUP: one advance per cycle, counter decrements; at count 1, next state = RUN.
  - RUN: ReadyxSO = 1. If RandReqxSI = 1, do one advance and register outputs:
    - W = new_state[RAND_BITS-1:0].
    - _BxDO <= W[2*SHARES-1:0].
    - _ZxDO <= W[RAND_BITS-1:2*SHARES].
    - RandValidxSO <= 1.
  - RUN with RandReqxSI = 0: state holds; _BxDO, _ZxDO, RandValidxSO <= 0 on the next edge. A word is never presented twice.
- Latency:
  - RandReqxSI high at edge k gives valid word after edge k.
  - Seed at edge t gives ReadyxSO after edge t+WARMUP_CYCLES.
- SeedValidxSI in any state has priority over RandReqxSI.
  - Same edge: outputs and RandValidxSO <= 0, reload as above.
  - In-flight word is dropped, not delayed.
- Word counter:
  - Increments per delivered word and saturates at RESEED_INTERVAL.
  - On reaching it, ReseedReqxSO <= 1 and stays high until next seed load.
  - Generation continues.
- Reset mid-RUN or mid-WARMUP: immediate return to reset values; a new seed is needed.
- ReadyxSO is registered: 1 exactly while FSM == RUN.

Test Plan:
- SHARES=2, WARMUP=0, seed 32'h1, RandReq held 1 → first word after ready: _BxDO=4'hD, _ZxDO=2'b10 (state 32'h6D), RandValid=1.
- Seed 32'h0 → behaves identically to seed 32'h1 (same first word 4'hD/2'b10).
- WARMUP=16, seed 32'hDEADBEEF → ReadyxSO rises exactly 16 cycles after seed edge; 100-word sequence matches the C model bit-exact.
- RUN, RandReq pattern 1,0,1 → valid 1,0,1; outputs 0 in the gap; 2nd delivered word equals the model's 2nd advance, with no repeat.
- RESEED_INTERVAL=4 → ReseedReq rises with the 4th valid word; new seed clears it; SeedValid+RandReq on the same edge → no valid word, FSM to WARMUP.
- Assert RstxBI low mid-WARMUP asynchronously → all outputs 0 before next edge; IDLE until reseeded.
